// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - centisecond stopwatch: prescaler, BCD time register, lap latch and control FSM
module stopwatch_core #(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int TICK_RATE_IN_HZ             = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [15:0] number,
    output logic        running,
    output logic        overflow,
    output logic        lap_active
);
    localparam int CYCLES_PER_TICK = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_RATE_IN_HZ;
    localparam int PW = (CYCLES_PER_TICK > 2) ? $clog2(CYCLES_PER_TICK) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_TICK - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUNNING  = 2'd1;
    localparam logic [1:0] ST_PAUSED   = 2'd2;
    localparam logic [1:0] ST_OVERFLOW = 2'd3;

    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic [15:0]   time_q;
    logic [15:0]   latch_q;
    logic [15:0]   time_inc;
    logic          lap_q;
    logic          prev_ss, prev_clear, prev_lap;
    logic          press_ss, press_clear, press_lap;
    logic          tick, at_max;

    assign press_ss    = btn_start_stop & ~prev_ss;
    assign press_clear = btn_clear & ~prev_clear;
    assign press_lap   = btn_lap & ~prev_lap;

    assign tick   = (state == ST_RUNNING) && (presc == PRESC_LAST);
    assign at_max = (time_q == 16'h9999);

    // Ripple BCD increment: each digit rolls 9->0 and carries into the next.
    always_comb begin
        logic       carry;
        logic [3:0] digit;
        time_inc = time_q;
        carry    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            digit = time_q[i*4 +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    time_inc[i*4 +: 4] = 4'd0;
                end else begin
                    time_inc[i*4 +: 4] = digit + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ss    <= 1'b0;
            prev_clear <= 1'b0;
            prev_lap   <= 1'b0;
        end else begin
            prev_ss    <= btn_start_stop;
            prev_clear <= btn_clear;
            prev_lap   <= btn_lap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            presc   <= '0;
            time_q  <= 16'h0000;
            latch_q <= 16'h0000;
            lap_q   <= 1'b0;
        end else if (press_clear) begin
            state   <= ST_IDLE;
            presc   <= '0;
            time_q  <= 16'h0000;
            latch_q <= 16'h0000;
            lap_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    presc <= '0;
                    if (press_ss) state <= ST_RUNNING;
                end
                ST_RUNNING: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (tick && !at_max) time_q <= time_inc;
                    if (press_ss) begin
                        state <= ST_PAUSED;
                    end else if (press_lap) begin
                        // Latch sees the pre-increment value when a tick coincides.
                        lap_q <= ~lap_q;
                        if (!lap_q) latch_q <= time_q;
                    end else if (tick && at_max) begin
                        state <= ST_OVERFLOW;
                    end
                end
                ST_PAUSED: begin
                    if (press_ss) state <= ST_RUNNING;
                    else if (press_lap) lap_q <= 1'b0;
                end
                default: begin
                    presc <= '0;
                end
            endcase
        end
    end

    assign number     = lap_q ? latch_q : time_q;
    assign running    = (state == ST_RUNNING);
    assign overflow   = (state == ST_OVERFLOW);
    assign lap_active = lap_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - scoreboard bench for stopwatch_core at 4 clocks per tick
module tb_stopwatch_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start_stop = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_lap = 1'b0;
    logic [15:0] number;
    logic        running, overflow, lap_active;

    stopwatch_core #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(400),
        .TICK_RATE_IN_HZ(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_start_stop(btn_start_stop),
        .btn_clear(btn_clear),
        .btn_lap(btn_lap),
        .number(number),
        .running(running),
        .overflow(overflow),
        .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] num;
        logic        run;
        logic        ovf;
        logic        lap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bool_t_dummy_unused_never u_unused_never ();

    // Monitor: compares the oldest expectation on the falling edge after it was queued.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (number !== e.num || running !== e.run || overflow !== e.ovf || lap_active !== e.lap) begin
                failures++;
                $display("FAIL %s: got number=%h running=%b overflow=%b lap_active=%b, want number=%h running=%b overflow=%b lap_active=%b",
                         e.name, number, running, overflow, lap_active, e.num, e.run, e.ovf, e.lap);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [15:0] num,
                              input logic run, input logic ovf, input logic lap);
        exp_t e;
        e.name = name; e.num = num; e.run = run; e.ovf = ovf; e.lap = lap;
        sb.push_back(e);
    endtask

    task automatic press_ss();
        btn_start_stop = 1'b1; cyc(1); btn_start_stop = 1'b0;
    endtask

    task automatic press_clear();
        btn_clear = 1'b1; cyc(1); btn_clear = 1'b0;
    endtask

    task automatic press_lap();
        btn_lap = 1'b1; cyc(1); btn_lap = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL timeout: got still running, want finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        cyc(1);
        expect_out("reset_hold", 16'h0000, 0, 0, 0);
        cyc(1);
        rst = 1'b0;
        cyc(1);

        // 1: asynchronous reset in the middle of a count
        press_ss();
        cyc(4*5 + 2);
        expect_out("pre_rst_count", 16'h0005, 1, 0, 0);
        cyc(1);
        rst = 1'b1;
        #1;
        expect_out("async_rst", 16'h0000, 0, 0, 0);
        cyc(3);
        rst = 1'b0;
        cyc(20);
        expect_out("idle_after_rst", 16'h0000, 0, 0, 0);
        cyc(1);

        // 2: count to 0123, then a held button gives exactly one press
        press_ss();
        cyc(4*123);
        expect_out("run_0123", 16'h0123, 1, 0, 0);
        btn_start_stop = 1'b1;
        cyc(20);
        expect_out("held_button", 16'h0123, 0, 0, 0);
        btn_start_stop = 1'b0;
        cyc(2);

        // 3: pause keeps prescaler phase
        do_reset();
        press_ss();
        cyc(4*10 + 2);
        expect_out("before_pause", 16'h0010, 1, 0, 0);
        press_ss();
        cyc(100);
        expect_out("paused", 16'h0010, 0, 0, 0);
        press_ss();
        cyc(1);
        expect_out("resume_phase", 16'h0011, 1, 0, 0);
        cyc(16);
        expect_out("resume_0015", 16'h0015, 1, 0, 0);
        cyc(1);

        // 4: lap latch
        do_reset();
        press_ss();
        cyc(4*42);
        press_lap();
        expect_out("lap_on", 16'h0042, 1, 0, 1);
        cyc(4*8 - 1);
        expect_out("lap_frozen", 16'h0042, 1, 0, 1);
        press_lap();
        expect_out("lap_off", 16'h0050, 1, 0, 0);
        cyc(1);

        // 5: overflow at 99.99
        do_reset();
        press_ss();
        cyc(4*9999);
        expect_out("at_9999", 16'h9999, 1, 0, 0);
        cyc(4);
        expect_out("overflow", 16'h9999, 0, 1, 0);
        press_ss();
        cyc(8);
        expect_out("ovf_ss_ignored", 16'h9999, 0, 1, 0);
        press_clear();
        expect_out("ovf_clear", 16'h0000, 0, 0, 0);
        cyc(8);
        expect_out("idle_after_clear", 16'h0000, 0, 0, 0);
        cyc(1);

        // 6: clear beats start_stop; tick and start_stop together
        do_reset();
        btn_clear = 1'b1; btn_start_stop = 1'b1;
        cyc(1);
        btn_clear = 1'b0; btn_start_stop = 1'b0;
        expect_out("clear_wins", 16'h0000, 0, 0, 0);
        cyc(8);
        expect_out("still_idle", 16'h0000, 0, 0, 0);
        cyc(1);
        press_ss();
        cyc(4*7 + 3);
        expect_out("at_0007", 16'h0007, 1, 0, 0);
        press_ss();
        expect_out("tick_and_pause", 16'h0008, 0, 0, 0);
        cyc(10);
        expect_out("paused_0008", 16'h0008, 0, 0, 0);
        cyc(2);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

module bool_t_dummy_unused_never;
endmodule
